fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port: imemReq  out  1  instruction-memory read request.
REQ-004 SHALL have port: imemAddr  out  64  byte address of the outstanding request.
REQ-005 SHALL have port: imemRdy  in  1  memory returns imemData this cycle; variable latency of 1 or more cycles.
REQ-006 SHALL have port: imemData  in  32  fetched instruction word.
REQ-007 SHALL have port: stall  in  1  downstream cannot accept instr this cycle.
REQ-008 SHALL have port: pcSrc  in  1  taken-branch redirect from the control unit.
REQ-009 SHALL have port: branchTarget  in  64  redirect byte address, computed downstream.
REQ-010 SHALL have port: instr  out  32  IF/ID instruction register.
REQ-011 SHALL have port: pcOut  out  64  byte address of instr.
REQ-012 SHALL have port: instrValid  out  1  instr/pcOut hold a live instruction.
REQ-013 SHALL have port: opcode  out  11  instr[31:21], combinational; drives control-unit decode.
REQ-014 SHALL have parameter: RESET_PC, default 64'h0, first fetch address.

Function
REQ-015 SHALL implement states BOOT, FETCH, HOLD; imemReq=1 only in FETCH.
REQ-016 SHALL transition BOOT->FETCH unconditionally one cycle after reset release, with reqAddr=pc.
REQ-017 SHALL drive imemAddr from register reqAddr and keep it stable while imemReq=1 and imemRdy=0.
REQ-018 SHALL treat an instruction as consumed on an edge with instrValid=1 and stall=0.
REQ-019 SHALL, on FETCH response (imemRdy=1) with output slot free (instrValid=0 or consumed same edge), load instr=imemData, pcOut=reqAddr, instrValid=1, reqAddr and pc = reqAddr+4.
REQ-020 SHALL, on FETCH response with slot occupied and stall=1, capture data/address into a one-entry skid buffer, set reqAddr=reqAddr+4, go to HOLD.
REQ-021 SHALL, in HOLD, move the skid entry into instr/pcOut on the consume edge, clear the skid, return to FETCH next cycle.
REQ-022 SHALL give redirect priority over any capture: on a consume edge with pcSrc=1, set instrValid=0, clear skid, pc=reqAddr=branchTarget with bits [1:0] forced to 0, enter FETCH.
REQ-023 SHALL discard a response arriving on the redirect edge.
REQ-024 SHALL set a squash flag if the redirect occurs while a request is outstanding (imemReq=1, imemRdy=0), drop that response when it arrives, clear squash, then issue the request at the new reqAddr.
REQ-025 SHALL ignore pcSrc when instrValid=0 or stall=1.
REQ-026 SHALL compute address increments modulo 2^64: 0xFFFF_FFFF_FFFF_FFFC+4 yields 0.
REQ-027 SHALL produce instrValid one edge after the response edge: 1-cycle fetch latency beyond memory latency.
REQ-028 SHALL never overwrite a valid, unconsumed instr.

Reset
REQ-029 SHALL, while reset=1, hold pc=reqAddr=RESET_PC, instr=0, pcOut=0, instrValid=0, skid empty, squash=0, state=BOOT, imemReq=0.
REQ-030 SHALL, on reset asserted mid-request, abandon the request with no further capture; a response during reset is ignored.

Verification
REQ-031 Bench SHALL check straight-line fetch: 1-cycle memory, stall=0 -> pcOut sequence 0,4,8,12 on consecutive cycles after instrValid first rises, opcode=instr[31:21].
REQ-032 Bench SHALL check stall with a 1-cycle memory: stall held 3 cycles while instr at 0x8 is valid -> instr/pcOut constant, skid holds 0xC, imemReq=0 in HOLD; after release pcOut=0xC follows 0x8 with no loss or duplication.
REQ-033 Bench SHALL check redirect: pcSrc=1, branchTarget=0x40 on consume edge of pcOut=0x10 -> instrValid=0 next cycle, next imemAddr=0x40, next valid pcOut=0x40.
REQ-034 Bench SHALL check squash: 3-cycle memory, redirect to 0x100 while request for 0x20 is outstanding -> 0x20 data never appears on instr; next valid pcOut=0x100.
REQ-035 Bench SHALL check async reset: reset pulsed between clock edges mid-request -> all outputs at reset values immediately; first imemAddr after release=RESET_PC.
REQ-036 Bench SHALL check wrap and alignment: branchTarget=0xFFFF_FFFF_FFFF_FFFE -> fetch 0xFFFF_FFFF_FFFF_FFFC, then 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. It issues requests to a
//               variable-latency instruction memory and keeps fetched
//               words in the IF/ID register (instr/pcOut/instrValid).
//               A one-entry skid buffer absorbs a response that arrives
//               while downstream is stalled. Taken-branch redirects take
//               priority over any capture. A redirect while a request is
//               still outstanding squashes that request's response.
//
// Ports       : clk           - sole clock, rising edge
//               reset         - asynchronous, active-high
//               imemReq       - instruction-memory read request (FETCH only)
//               imemAddr[63:0]- byte address of the outstanding request
//               imemRdy       - memory returns imemData this cycle
//               imemData[31:0]- fetched instruction word
//               stall         - downstream cannot accept instr this cycle
//               pcSrc         - taken-branch redirect
//               branchTarget  - redirect byte address (low 2 bits ignored)
//               instr[31:0]   - IF/ID instruction register
//               pcOut[63:0]   - byte address of instr
//               instrValid    - instr/pcOut hold a live instruction
//               opcode[10:0]  - instr[31:21], combinational
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [63:0] imemAddr,
    input  logic        imemRdy,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic [63:0] branchTarget,
    output logic [31:0] instr,
    output logic [63:0] pcOut,
    output logic        instrValid,
    output logic [10:0] opcode
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [63:0] r_pc;          // next sequential / redirected fetch address
    logic [63:0] r_req_addr;    // address presented on imemAddr
    logic [31:0] r_instr;
    logic [63:0] r_pc_out;
    logic        r_valid;
    logic        r_skid_valid;
    logic [31:0] r_skid_data;
    logic [63:0] r_skid_addr;
    logic        r_squash;      // drop the response of the in-flight request

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic [63:0] w_req_addr_nxt;
    logic [31:0] w_instr_nxt;
    logic [63:0] w_pc_out_nxt;
    logic        w_valid_nxt;
    logic        w_skid_valid_nxt;
    logic [31:0] w_skid_data_nxt;
    logic [63:0] w_skid_addr_nxt;
    logic        w_squash_nxt;
    logic        w_imem_req;

    logic        w_consume;
    logic        w_redirect;
    logic [63:0] w_target;
    logic [63:0] w_req_inc;

    // The slot is consumed whenever a live instruction is not stalled;
    // a redirect is only honoured on such an edge.
    assign w_consume  = r_valid & ~stall;
    assign w_redirect = w_consume & pcSrc;
    assign w_target   = branchTarget & ~64'h3;
    // Natural 64-bit wrap: ...FFFC + 4 = 0.
    assign w_req_inc  = r_req_addr + 64'd4;

    // ------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_instr      <= 32'h0;
            r_pc_out     <= 64'h0;
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 32'h0;
            r_skid_addr  <= 64'h0;
            r_squash     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req_addr   <= w_req_addr_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_addr  <= w_skid_addr_nxt;
            r_squash     <= w_squash_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_addr_nxt   = r_req_addr;
        w_instr_nxt      = r_instr;
        w_pc_out_nxt     = r_pc_out;
        w_valid_nxt      = r_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_addr_nxt  = r_skid_addr;
        w_squash_nxt     = r_squash;
        w_imem_req       = 1'b0;

        // A consumed slot empties unless something refills it below.
        if (w_consume) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            BOOT: begin
                w_req_addr_nxt = r_pc;
                w_state_nxt    = FETCH;
            end

            FETCH: begin
                w_imem_req = 1'b1;
                if (w_redirect) begin
                    w_skid_valid_nxt = 1'b0;
                    w_pc_nxt         = w_target;
                    if (imemRdy) begin
                        // Response on the redirect edge is simply dropped.
                        w_req_addr_nxt = w_target;
                        w_squash_nxt   = 1'b0;
                    end else begin
                        // Request still in flight: keep imemAddr stable
                        // until its response is swallowed, then move to
                        // the target held in r_pc.
                        w_squash_nxt = 1'b1;
                    end
                end else if (imemRdy) begin
                    if (r_squash) begin
                        w_squash_nxt   = 1'b0;
                        w_req_addr_nxt = r_pc;
                    end else if (!r_valid || w_consume) begin
                        w_instr_nxt    = imemData;
                        w_pc_out_nxt   = r_req_addr;
                        w_valid_nxt    = 1'b1;
                        w_req_addr_nxt = w_req_inc;
                        w_pc_nxt       = w_req_inc;
                    end else begin
                        // Slot occupied and stalled: park the word.
                        w_skid_valid_nxt = 1'b1;
                        w_skid_data_nxt  = imemData;
                        w_skid_addr_nxt  = r_req_addr;
                        w_req_addr_nxt   = w_req_inc;
                        w_pc_nxt         = w_req_inc;
                        w_state_nxt      = HOLD;
                    end
                end
            end

            HOLD: begin
                // instrValid is always set here; no request is issued.
                if (w_redirect) begin
                    w_skid_valid_nxt = 1'b0;
                    w_pc_nxt         = w_target;
                    w_req_addr_nxt   = w_target;
                    w_state_nxt      = FETCH;
                end else if (w_consume) begin
                    w_instr_nxt      = r_skid_data;
                    w_pc_out_nxt     = r_skid_addr;
                    w_valid_nxt      = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                    w_state_nxt      = FETCH;
                end
            end

            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign imemReq    = w_imem_req;
    assign imemAddr   = r_req_addr;
    assign instr      = r_instr;
    assign pcOut      = r_pc_out;
    assign instrValid = r_valid;
    assign opcode     = r_instr[31:21];

endmodule
`default_nettype wire
